accel_spi_sequencer: RTL and testbench

Autonomous transaction sequencer for the on-board ADXL362 accelerometer. It sits between the processor-side register interface and the byte-level SPI controller. After reset it verifies the device ID and writes the configuration registers. It then burst-reads X/Y/Z data every `SAMPLE_PERIOD` cycles and presents the latest sample as stable registers, so the CPU never has to stall on individual SPI bytes.

---
 rtl/accel_pkg.sv | 38 +++
 rtl/spi_txn_engine.sv | 124 ++++++++++++
 rtl/accel_spi_sequencer.sv | 177 +++++++++++++++++
 tb/tb_accel_spi_sequencer.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/accel_pkg.sv
// Shared constants for the ADXL362 sequencer: opcodes, register map, config
// values, FSM encodings and the per-transaction byte ROM.
package accel_pkg;

  localparam logic [7:0] CMD_WR     = 8'h0A;
  localparam logic [7:0] CMD_RD     = 8'h0B;
  localparam logic [7:0] DEVID_AD   = 8'h00;
  localparam logic [7:0] FILTER_CTL = 8'h2C;
  localparam logic [7:0] POWER_CTL  = 8'h2D;
  localparam logic [7:0] XDATA_L    = 8'h0E;
  localparam logic [7:0] FILTER_VAL = 8'h13;  // +/-2 g, 100 Hz ODR
  localparam logic [7:0] POWER_VAL  = 8'h02;  // measurement mode
  localparam logic [7:0] DEVID_EXP  = 8'hAD;

  typedef enum logic [2:0] {
    ST_PWR_WAIT, ST_ID_RD, ST_CFG_FILT, ST_CFG_PWR, ST_IDLE, ST_SAMPLE, ST_ERROR
  } top_st_e;

  typedef enum logic [2:0] {
    E_IDLE, E_SETUP, E_WREADY, E_TX, E_WRX, E_GAP
  } eng_st_e;

  function automatic logic [7:0] txn_byte(top_st_e st, logic [2:0] idx);
    case (st)
      ST_ID_RD:    return (idx == 3'd0) ? CMD_RD : ((idx == 3'd1) ? DEVID_AD : 8'h00);
      ST_CFG_FILT: return (idx == 3'd0) ? CMD_WR : ((idx == 3'd1) ? FILTER_CTL : FILTER_VAL);
      ST_CFG_PWR:  return (idx == 3'd0) ? CMD_WR : ((idx == 3'd1) ? POWER_CTL : POWER_VAL);
      ST_SAMPLE:   return (idx == 3'd0) ? CMD_RD : ((idx == 3'd1) ? XDATA_L : 8'h00);
      default:     return 8'h00;
    endcase
  endfunction

  // Sample bursts are launched from IDLE, so IDLE already reports the burst length.
  function automatic logic [3:0] txn_len(top_st_e st);
    return (st == ST_IDLE || st == ST_SAMPLE) ? 4'd8 : 4'd3;
  endfunction

endpackage

// File: rtl/spi_txn_engine.sv
// One chip-select framed SPI transaction: cs setup, byte-by-byte handshake
// with a single outstanding byte, then a guaranteed cs-high gap.
module spi_txn_engine
  import accel_pkg::*;
#(
  parameter int CS_GAP = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic [3:0] nbytes,
  input  logic [7:0] src_byte,
  output logic [2:0] src_idx,
  input  logic       tx_ready,
  output logic       tx_dv,
  output logic [7:0] tx_byte,
  input  logic       rx_dv,
  input  logic [7:0] rx_byte,
  output logic       rx_vld,
  output logic [2:0] rx_idx,
  output logic [7:0] rx_data,
  output logic       cs_n,
  output logic       busy,
  output logic       idle,
  output logic       done
);

  localparam int GW = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;
  localparam logic [GW-1:0] GAP_LD = GW'(CS_GAP - 1);

  eng_st_e       st_q, st_d;
  logic [GW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [2:0]    last_q, last_d;
  logic          cs_n_q, cs_n_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [7:0]    tx_byte_q, tx_byte_d;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      st_q      <= E_IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      last_q    <= '0;
      cs_n_q    <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      tx_byte_q <= 8'h00;
    end else begin
      st_q      <= st_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      last_q    <= last_d;
      cs_n_q    <= cs_n_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      tx_byte_q <= tx_byte_d;
    end
  end

  always_comb begin
    st_d      = st_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    last_d    = last_q;
    cs_n_d    = cs_n_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    tx_byte_d = tx_byte_q;
    case (st_q)
      E_IDLE: if (start) begin
        st_d   = E_SETUP;
        cnt_d  = GAP_LD;
        idx_d  = 3'd0;
        last_d = 3'(nbytes - 4'd1);
        cs_n_d = 1'b0;
        busy_d = 1'b1;
      end
      E_SETUP: begin
        if (cnt_q == '0) st_d = E_WREADY;
        else             cnt_d = cnt_q - GW'(1);
      end
      E_WREADY: if (tx_ready) begin
        st_d      = E_TX;
        tx_byte_d = src_byte;
      end
      // tx_dv is gated by tx_ready, so a ready drop here just stalls the strobe.
      E_TX: if (tx_ready) st_d = E_WRX;
      E_WRX: if (rx_dv) begin
        if (idx_q == last_q) begin
          st_d   = E_GAP;
          cs_n_d = 1'b1;
          cnt_d  = GAP_LD;
        end else begin
          st_d  = E_WREADY;
          idx_d = idx_q + 3'd1;
        end
      end
      E_GAP: begin
        if (cnt_q == '0) begin
          st_d   = E_IDLE;
          busy_d = 1'b0;
          done_d = 1'b1;
        end else begin
          cnt_d = cnt_q - GW'(1);
        end
      end
      default: st_d = E_IDLE;
    endcase
  end

  assign tx_dv   = (st_q == E_TX) && tx_ready;
  assign tx_byte = tx_byte_q;
  assign rx_vld  = (st_q == E_WRX) && rx_dv;
  assign rx_idx  = idx_q;
  assign rx_data = rx_byte;
  assign src_idx = idx_q;
  assign cs_n    = cs_n_q;
  assign busy    = busy_q;
  assign idle    = (st_q == E_IDLE);
  assign done    = done_q;

endmodule

// File: rtl/accel_spi_sequencer.sv
// ADXL362 autonomous sequencer: power-up wait, ID check, configuration, then
// periodic X/Y/Z burst reads presented as stable registers.
module accel_spi_sequencer
  import accel_pkg::*;
#(
  parameter int SAMPLE_PERIOD  = 100000,
  parameter int POWERUP_CYCLES = 500000,
  parameter int CS_GAP         = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        en,
  output logic [7:0]  tx_byte,
  output logic        tx_dv,
  input  logic        tx_ready,
  input  logic        rx_dv,
  input  logic [7:0]  rx_byte,
  output logic        cs_n,
  output logic [15:0] x_data,
  output logic [15:0] y_data,
  output logic [15:0] z_data,
  output logic        sample_valid,
  output logic        cfg_done,
  output logic        id_err,
  output logic        busy
);

  localparam int TW = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
  localparam int PW = (POWERUP_CYCLES > 1) ? $clog2(POWERUP_CYCLES) : 1;
  localparam logic [TW-1:0] PER_LD = TW'(SAMPLE_PERIOD - 1);
  localparam logic [PW-1:0] PWR_LAST = PW'(POWERUP_CYCLES - 1);

  top_st_e       st_q, st_d;
  logic [PW-1:0] pwr_q, pwr_d;
  logic [TW-1:0] per_q, per_d;
  logic          act_q, act_d;
  logic          id_ok_q, id_ok_d;
  logic          cfg_done_q, cfg_done_d;
  logic          id_err_q, id_err_d;
  logic [15:0]   x_q, x_d, y_q, y_d, z_q, z_d;
  logic          sv_q, sv_d;
  logic [39:0]   rxb_q, rxb_d;

  logic       eng_start, eng_idle, eng_done, eng_rx_vld;
  logic [2:0] eng_src_idx, eng_rx_idx;
  logic [7:0] eng_rx_data;

  spi_txn_engine #(.CS_GAP(CS_GAP)) u_eng (
    .clock    (clock),
    .reset    (reset),
    .start    (eng_start),
    .nbytes   (txn_len(st_q)),
    .src_byte (txn_byte(st_q, eng_src_idx)),
    .src_idx  (eng_src_idx),
    .tx_ready (tx_ready),
    .tx_dv    (tx_dv),
    .tx_byte  (tx_byte),
    .rx_dv    (rx_dv),
    .rx_byte  (rx_byte),
    .rx_vld   (eng_rx_vld),
    .rx_idx   (eng_rx_idx),
    .rx_data  (eng_rx_data),
    .cs_n     (cs_n),
    .busy     (busy),
    .idle     (eng_idle),
    .done     (eng_done)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      st_q       <= ST_PWR_WAIT;
      pwr_q      <= '0;
      per_q      <= '0;
      act_q      <= 1'b0;
      id_ok_q    <= 1'b0;
      cfg_done_q <= 1'b0;
      id_err_q   <= 1'b0;
      x_q        <= 16'h0000;
      y_q        <= 16'h0000;
      z_q        <= 16'h0000;
      sv_q       <= 1'b0;
      rxb_q      <= '0;
    end else begin
      st_q       <= st_d;
      pwr_q      <= pwr_d;
      per_q      <= per_d;
      act_q      <= act_d;
      id_ok_q    <= id_ok_d;
      cfg_done_q <= cfg_done_d;
      id_err_q   <= id_err_d;
      x_q        <= x_d;
      y_q        <= y_d;
      z_q        <= z_d;
      sv_q       <= sv_d;
      rxb_q      <= rxb_d;
    end
  end

  always_comb begin
    st_d       = st_q;
    pwr_d      = pwr_q;
    per_d      = (per_q != '0) ? per_q - TW'(1) : per_q;
    act_d      = act_q;
    id_ok_d    = id_ok_q;
    cfg_done_d = cfg_done_q;
    id_err_d   = id_err_q;
    x_d        = x_q;
    y_d        = y_q;
    z_d        = z_q;
    sv_d       = 1'b0;
    rxb_d      = rxb_q;
    eng_start  = 1'b0;

    case (st_q)
      ST_PWR_WAIT: begin
        if (pwr_q == PWR_LAST) st_d = ST_ID_RD;
        else                   pwr_d = pwr_q + PW'(1);
      end
      ST_ID_RD, ST_CFG_FILT, ST_CFG_PWR: begin
        if (!act_q && eng_idle) begin
          eng_start = 1'b1;
          act_d     = 1'b1;
        end
        if (eng_done) begin
          act_d = 1'b0;
          case (st_q)
            ST_ID_RD: begin
              st_d     = id_ok_q ? ST_CFG_FILT : ST_ERROR;
              id_err_d = !id_ok_q;
            end
            ST_CFG_FILT: st_d = ST_CFG_PWR;
            default: begin
              st_d       = ST_IDLE;
              cfg_done_d = 1'b1;
            end
          endcase
        end
      end
      // Launch straight from IDLE so burst starts are exactly SAMPLE_PERIOD apart.
      ST_IDLE: if (per_q == '0 && en && eng_idle) begin
        eng_start = 1'b1;
        act_d     = 1'b1;
        per_d     = PER_LD;
        st_d      = ST_SAMPLE;
      end
      ST_SAMPLE: if (eng_done) begin
        act_d = 1'b0;
        st_d  = ST_IDLE;
      end
      default: st_d = st_q;
    endcase

    if (eng_rx_vld) begin
      if (st_q == ST_ID_RD && eng_rx_idx == 3'd2)
        id_ok_d = (eng_rx_data == DEVID_EXP);
      // After byte 6 the shift window holds bytes 2..6 oldest-first; byte 7 is ZH.
      if (st_q == ST_SAMPLE) begin
        if (eng_rx_idx == 3'd7) begin
          x_d  = {rxb_q[31:24], rxb_q[39:32]};
          y_d  = {rxb_q[15:8],  rxb_q[23:16]};
          z_d  = {eng_rx_data,  rxb_q[7:0]};
          sv_d = 1'b1;
        end else begin
          rxb_d = {rxb_q[31:0], eng_rx_data};
        end
      end
    end
  end

  assign x_data       = x_q;
  assign y_data       = y_q;
  assign z_data       = z_q;
  assign sample_valid = sv_q;
  assign cfg_done     = cfg_done_q;
  assign id_err       = id_err_q;

endmodule

// File: tb/tb_accel_spi_sequencer.sv
// Directed bench: SPI device model plus table-driven burst vectors and
// hand-written power-up, backpressure, enable, reset and bad-ID sequences.
module tb_accel_spi_sequencer;

  localparam int SP  = 300;
  localparam int PU  = 40;
  localparam int GAP = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        en = 1'b0;
  logic        tx_ready = 1'b1;
  logic        rx_dv;
  logic [7:0]  rx_byte;
  logic [7:0]  tx_byte;
  logic        tx_dv;
  logic        cs_n;
  logic [15:0] x_data, y_data, z_data;
  logic        sample_valid, cfg_done, id_err, busy;

  always #5 clock = ~clock;

  accel_spi_sequencer #(.SAMPLE_PERIOD(SP), .POWERUP_CYCLES(PU), .CS_GAP(GAP)) dut (
    .clock(clock), .reset(reset), .en(en),
    .tx_byte(tx_byte), .tx_dv(tx_dv), .tx_ready(tx_ready),
    .rx_dv(rx_dv), .rx_byte(rx_byte), .cs_n(cs_n),
    .x_data(x_data), .y_data(y_data), .z_data(z_data),
    .sample_valid(sample_valid), .cfg_done(cfg_done), .id_err(id_err), .busy(busy)
  );

  // Device model state
  logic [7:0]  devid = 8'hAD;
  logic [47:0] samp = '0;  // {XL,XH,YL,YH,ZL,ZH}, first byte on the wire in the MSBs
  logic [7:0]  fr [8];
  logic [7:0]  resp;
  logic [7:0]  tx_log [$];
  int          fall_q [$];
  int cyc = 0, fr_n = 0, last_len = 0, fall_cnt = 0, last_fall = 0;
  int viol = 0, tx_total = 0, sv_cnt = 0, dly = 0;
  bit pend = 0;
  logic prev_cs = 1'b1;

  always @(posedge clock) cyc <= cyc + 1;
  always @(posedge clock) if (!reset && sample_valid) sv_cnt <= sv_cnt + 1;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      rx_dv <= 1'b0; rx_byte <= 8'h00; pend <= 0; dly <= 0; fr_n <= 0; prev_cs <= 1'b1;
    end else begin
      prev_cs <= cs_n;
      rx_dv   <= 1'b0;
      if (pend) begin
        if (dly == 0) begin rx_dv <= 1'b1; rx_byte <= resp; pend <= 0; end
        else dly <= dly - 1;
      end
      if (prev_cs && !cs_n) begin
        fall_cnt <= fall_cnt + 1; last_fall <= cyc; fr_n <= 0; fall_q.push_back(cyc);
      end
      if (!prev_cs && cs_n) last_len <= fr_n;
      if (tx_dv) begin
        if (!tx_ready || cs_n || pend || (fr_n == 0 && (cyc - last_fall) < GAP)) viol <= viol + 1;
        tx_log.push_back(tx_byte);
        tx_total <= tx_total + 1;
        if (fr_n < 8) fr[fr_n[2:0]] <= tx_byte;
        fr_n <= fr_n + 1;
        pend <= 1; dly <= 2;
        if (fr_n == 2 && fr[0] == 8'h0B && fr[1] == 8'h00) resp <= devid;
        else if (fr_n >= 2 && fr_n < 8 && fr[0] == 8'h0B && fr[1] == 8'h0E)
          resp <= samp[47 - 8*(fr_n-2) -: 8];
        else resp <= 8'h00;
      end
    end
  end

  int total = 0, passed = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic wait_sv(input int base, input int maxc);
    int i;
    for (i = 0; i < maxc && sv_cnt <= base; i++) @(negedge clock);
    chk("sample_valid_seen", (sv_cnt > base), 1);
  endtask

  task automatic wait_byte(input int k, input int maxc);
    int i;
    for (i = 0; i < maxc && !(fr_n == k && !cs_n); i++) @(negedge clock);
    chk("reached_burst_byte", (fr_n == k && !cs_n), 1);
  endtask

  typedef struct {
    logic [47:0] rb;
    logic [15:0] ex, ey, ez;
  } vec_t;
  vec_t vec [5];

  logic [7:0] exp_cfg [9];
  int t [3];
  int b, tx0, f0, rel, low, dvl, s0;

  initial begin
    vec[0] = '{48'h3412CDABFF0F, 16'h1234, 16'hABCD, 16'h0FFF};
    vec[1] = '{48'h0080FF7F0100, 16'h8000, 16'h7FFF, 16'h0001};
    vec[2] = '{48'hFFFF00005AA5, 16'hFFFF, 16'h0000, 16'hA55A};
    vec[3] = '{48'h112233445566, 16'h2211, 16'h4433, 16'h6655};
    vec[4] = '{48'h7856BC9AF0DE, 16'h5678, 16'h9ABC, 16'hDEF0};
    exp_cfg = '{8'h0B, 8'h00, 8'h00, 8'h0A, 8'h2C, 8'h13, 8'h0A, 8'h2D, 8'h02};

    // Reset state
    repeat (3) @(negedge clock);
    chk("rst_cs_n", cs_n, 1);
    chk("rst_tx_dv", tx_dv, 0);
    chk("rst_tx_byte", tx_byte, 8'h00);
    chk("rst_xyz", {x_data, y_data, z_data}, 0);
    chk("rst_sample_valid", sample_valid, 0);
    chk("rst_cfg_done", cfg_done, 0);
    chk("rst_id_err", id_err, 0);
    chk("rst_busy", busy, 0);

    // Power-up: ID read and configuration
    tx_log.delete(); fall_q.delete(); f0 = fall_cnt;
    reset = 1'b0; rel = cyc;
    for (int i = 0; i < 3000 && !cfg_done; i++) @(negedge clock);
    chk("cfg_done_set", cfg_done, 1);
    chk("cfg_byte_count", tx_log.size(), 9);
    for (int i = 0; i < 9; i++) chk($sformatf("cfg_byte%0d", i), (i < tx_log.size()) ? tx_log[i] : 8'hxx, exp_cfg[i]);
    chk("cfg_frames", fall_cnt - f0, 3);
    chk("pwr_delay", (fall_q.size() > 0) && (fall_q[0] - rel >= PU), 1);
    chk("cfg_id_err", id_err, 0);
    repeat (2) @(negedge clock);
    chk("cfg_busy_low", busy, 0);

    // en low: nothing happens
    tx0 = tx_total;
    repeat (100) @(negedge clock);
    chk("en_low_no_tx", tx_total - tx0, 0);

    // Table-driven burst decode
    s0 = tx_log.size();
    for (int i = 0; i < 3; i++) begin
      samp = vec[i].rb; b = sv_cnt;
      en = 1'b1;
      wait_sv(b, 2 * SP);
      t[i] = last_fall;
      chk($sformatf("v%0d_x", i), x_data, vec[i].ex);
      chk($sformatf("v%0d_y", i), y_data, vec[i].ey);
      chk($sformatf("v%0d_z", i), z_data, vec[i].ez);
      repeat (3) @(negedge clock);
      chk($sformatf("v%0d_one_pulse", i), sv_cnt - b, 1);
    end
    chk("burst_b0", tx_log[s0], 8'h0B);
    chk("burst_b1", tx_log[s0+1], 8'h0E);
    chk("burst_dummies", {tx_log[s0+2], tx_log[s0+3], tx_log[s0+4], tx_log[s0+5], tx_log[s0+6], tx_log[s0+7]}, 0);
    chk("period_1", t[1] - t[0], SP);
    chk("period_2", t[2] - t[1], SP);

    // Backpressure mid-burst
    samp = vec[3].rb; b = sv_cnt; tx0 = tx_total;
    wait_byte(3, 2 * SP);
    tx_ready = 1'b0; dvl = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clock);
      if (tx_dv) dvl++;
    end
    chk("bp_no_dv", dvl, 0);
    chk("bp_busy", busy, 1);
    tx_ready = 1'b1;
    wait_sv(b, 1000);
    chk("bp_xyz", {x_data, y_data, z_data}, {vec[3].ex, vec[3].ey, vec[3].ez});
    repeat (5) @(negedge clock);
    chk("bp_frame_len", last_len, 8);
    chk("bp_tx_count", tx_total - tx0, 8);

    // en dropped during byte 5
    samp = vec[4].rb; b = sv_cnt;
    wait_byte(4, 2 * SP);
    en = 1'b0;
    wait_sv(b, 1000);
    chk("en_xyz", {x_data, y_data, z_data}, {vec[4].ex, vec[4].ey, vec[4].ez});
    repeat (5) @(negedge clock);
    chk("en_one_pulse", sv_cnt - b, 1);
    tx0 = tx_total; f0 = fall_cnt;
    repeat (3 * SP) @(negedge clock);
    chk("en_off_no_tx", tx_total - tx0, 0);
    chk("en_off_no_cs", fall_cnt - f0, 0);
    en = 1'b1;
    @(negedge clock);
    chk("en_rise_start", cs_n, 0);
    b = sv_cnt;
    wait_sv(b - 1, 1000);

    // Reset mid-burst (during byte 4)
    wait_sv(b, 2 * SP);
    wait_byte(3, 2 * SP);
    @(posedge clock); #2 reset = 1'b1; #1;
    chk("rmb_cs_n", cs_n, 1);
    chk("rmb_xyz", {x_data, y_data, z_data}, 0);
    chk("rmb_cfg_done", cfg_done, 0);
    chk("rmb_busy", busy, 0);
    tx_log.delete(); fall_q.delete();
    @(negedge clock); reset = 1'b0; rel = cyc;
    for (int i = 0; i < 3000 && !cfg_done; i++) @(negedge clock);
    chk("rmb_cfg_again", cfg_done, 1);
    chk("rmb_id_bytes", (tx_log.size() >= 3) ? {tx_log[0], tx_log[1], tx_log[2]} : 24'hxxxxxx, 24'h0B0000);
    chk("rmb_pwr_delay", (fall_q.size() > 0) && (fall_q[0] - rel >= PU), 1);

    // Bad device ID
    @(negedge clock); reset = 1'b1; en = 1'b0; devid = 8'h00;
    repeat (2) @(negedge clock); reset = 1'b0;
    for (int i = 0; i < 3000 && !id_err; i++) @(negedge clock);
    chk("bad_id_err", id_err, 1);
    chk("bad_cfg_done", cfg_done, 0);
    tx0 = tx_total; low = 0;
    for (int i = 0; i < 10000; i++) begin
      @(negedge clock);
      if (!cs_n) low++;
    end
    chk("bad_no_tx", tx_total - tx0, 0);
    chk("bad_cs_high", low, 0);
    chk("bad_id_held", id_err, 1);

    chk("protocol_violations", viol, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
